// File: rtl/weight_accumulator.sv
// weight_accumulator: FIFO-buffered float32 weight summation per timestep, result latched on DONE.
// Optional macro WEIGHT_COUNT_EN adds a saturating per-timestep accepted-weight count output.
module Addition_Subtraction (
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        add_bar_sub,
    output logic        exception,
    output logic [31:0] result
);
    logic [31:0] b_eff, big, sml;
    logic [9:0]  e_big, e_sml, shift, e_norm, e_fin;
    logic [26:0] m_big, m_sml, m_al, norm;
    logic [27:0] sum;
    logic [4:0]  msb, lz;
    logic [24:0] mant;
    logic [22:0] frac;
    logic        a_ge, special, rnd;
    always_comb begin
        b_eff   = {b_operand[31] ^ add_bar_sub, b_operand[30:0]};
        a_ge    = a_operand[30:0] >= b_eff[30:0];
        big     = a_ge ? a_operand : b_eff;
        sml     = a_ge ? b_eff : a_operand;
        e_big   = {2'b00, (big[30:23] == 8'd0) ? 8'd1 : big[30:23]};
        e_sml   = {2'b00, (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23]};
        m_big   = {|big[30:23], big[22:0], 3'b000};
        m_sml   = {|sml[30:23], sml[22:0], 3'b000};
        shift   = e_big - e_sml;
        // Bits shifted out of the smaller operand collapse into a sticky LSB for rounding.
        m_al    = (shift > 10'd26) ? {26'd0, |m_sml}
                : (m_sml >> shift) | {26'd0, |(m_sml & ~({27{1'b1}} << shift))};
        sum     = (big[31] ^ sml[31]) ? {1'b0, m_big} - {1'b0, m_al} : {1'b0, m_big} + {1'b0, m_al};
        msb     = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum[i]) msb = 5'(i);
        lz      = 5'd26 - msb;
        if (sum[27]) begin
            norm   = {sum[27:2], |sum[1:0]};
            e_norm = e_big + 10'd1;
        end else if (e_big > {5'd0, lz}) begin
            norm   = sum[26:0] << lz;
            e_norm = e_big - {5'd0, lz};
        end else begin
            norm   = sum[26:0] << (e_big - 10'd1);
            e_norm = 10'd0;
        end
        rnd     = norm[2] & (norm[3] | norm[1] | norm[0]);
        mant    = {1'b0, norm[26:3]} + {24'd0, rnd};
        e_fin   = mant[24] ? e_norm + 10'd1 : (e_norm == 10'd0 && mant[23]) ? 10'd1 : e_norm;
        frac    = mant[24] ? mant[23:1] : mant[22:0];
        special = &a_operand[30:23] | &b_operand[30:23];
        exception = special | (sum != 28'd0 && e_fin >= 10'd255);
        result  = special ? (&a_operand[30:23] ? a_operand : b_eff)
                : (sum == 28'd0) ? 32'd0
                : (e_fin >= 10'd255) ? {big[31], 8'hFF, 23'd0}
                : {big[31], e_fin[7:0], frac};
    end
endmodule

module weight_accumulator #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] weight_in,
    input  logic        weight_valid,
    output logic        weight_ready,
    input  logic        timestep_end,
    output logic [31:0] input_weight,
    output logic        weight_done,
    output logic        exception
`ifdef WEIGHT_COUNT_EN
    ,
    output logic [7:0]  weight_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;
    state_t      state, state_nxt;
    logic [31:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] fifo_cnt;
    logic [31:0] acc, operand, add_result;
    logic        busy, sticky_exc, add_exc, push, pop, fifo_empty, fifo_full, done_entry;

    assign fifo_empty = fifo_cnt == '0;
    assign fifo_full  = fifo_cnt == (AW+1)'(FIFO_DEPTH);
    assign push       = weight_valid && weight_ready;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ACCUM;
        else       state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   state_nxt = timestep_end ? DRAIN : ACCUM;
            DRAIN:   state_nxt = (fifo_empty && !busy) ? DONE : DRAIN;
            default: state_nxt = ACCUM;
        endcase
    end

    // An ISSUE waits for the previous WRITE, giving one add per two cycles.
    always_comb begin
        weight_ready = state == ACCUM && !fifo_full;
        pop          = state != DONE && !busy && !fifo_empty;
        done_entry   = state == DRAIN && state_nxt == DONE;
    end

    always_ff @(posedge clk)
        if (push) fifo_mem[wr_ptr] <= weight_in;

    Addition_Subtraction u_add (
        .a_operand  (acc),
        .b_operand  (operand),
        .add_bar_sub(1'b0),
        .exception  (add_exc),
        .result     (add_result)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            busy         <= 1'b0;
            operand      <= 32'd0;
            acc          <= 32'd0;
            sticky_exc   <= 1'b0;
            input_weight <= 32'd0;
            exception    <= 1'b0;
            weight_done  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                operand <= fifo_mem[rd_ptr];
            end
            fifo_cnt    <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
            busy        <= pop;
            weight_done <= done_entry;
            if (done_entry) begin
                input_weight <= acc;
                exception    <= sticky_exc;
                acc          <= 32'd0;
                sticky_exc   <= 1'b0;
            end else if (busy) begin
                acc        <= add_result;
                sticky_exc <= sticky_exc | add_exc;
            end
        end

`ifdef WEIGHT_COUNT_EN
    logic [7:0] cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt          <= 8'd0;
            weight_count <= 8'd0;
        end else if (done_entry) begin
            weight_count <= cnt;
            cnt          <= 8'd0;
        end else if (push && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
`endif
endmodule

// File: doc/weight_accumulator.md
WEIGHT_ACCUMULATOR -- requirements
Module: weight_accumulator

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-high reset, listed first as follows:
- clk  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  asynchronous active-high reset.
REQ-002 The module SHALL have one parameter:
- FIFO_DEPTH  default 4  number of buffered incoming weights; power of two, 2..16.
REQ-003 The module SHALL have these ports:
- weight_in  input  32  incoming synaptic weight, IEEE-754 single precision.
- weight_valid  input  1  weight_in is valid this cycle.
- weight_ready  output  1  module accepts weight_in this cycle.
- timestep_end  input  1  single-cycle pulse that closes the current timestep.
- input_weight  output  32  summed weight for the closed timestep; feeds the potential adder.
- weight_done  output  1  one-cycle pulse; input_weight is newly valid.
- exception  output  1  an adder exception occurred during the closed timestep.

Function
REQ-004 A weight SHALL be accepted on a rising edge where weight_valid=1 and weight_ready=1, and pushed into a FIFO of FIFO_DEPTH entries.
REQ-005 weight_ready SHALL be 1 only when the state is ACCUM and the FIFO is not full; a pop in the same cycle SHALL NOT make room for a push.
REQ-006 Summation SHALL use the codebase single-precision Addition_Subtraction unit with the operation set to add; the accumulator's reset value SHALL be 0x00000000.
REQ-007 Each add SHALL take 2 cycles:
- ISSUE: pop the FIFO head into an operand register.
- WRITE: accumulator <= accumulator + operand.
- Throughput: 1 weight per 2 cycles.
REQ-008 A new ISSUE SHALL NOT begin until the previous WRITE has completed; there is no forwarding.
REQ-009 The state machine SHALL have three states:
- ACCUM: accepts and sums weights; timestep_end=1 moves to DRAIN on the next edge.
- DRAIN: no new weights; keeps popping until the FIFO is empty and no add is in flight, then moves to DONE.
- DONE: one cycle, then returns to ACCUM.
REQ-010 A weight accepted in the same cycle as timestep_end SHALL belong to the closing timestep.
REQ-011 timestep_end SHALL be ignored while the state is DRAIN or DONE.
REQ-012 On entry to DONE the module SHALL register the following in the same edge:
- input_weight <= accumulator.
- exception <= sticky OR of adder Exception over the timestep.
- weight_done <= 1 for exactly one cycle.
- accumulator and sticky exception cleared to 0.
REQ-013 input_weight and exception SHALL hold their values until the next DONE entry.
REQ-014 A timestep with no weights SHALL produce input_weight=0x00000000 with weight_done high 2 cycles after the timestep_end edge.
REQ-015 Adder overflow or NaN results SHALL be accumulated as produced, with no saturation; they are flagged only via exception.

Reset
REQ-016 While reset=1, the module SHALL clear state to ACCUM, empty the FIFO, cancel any in-flight add, and drive the following values:
- accumulator, input_weight = 0x00000000.
- weight_done, exception = 0.
- weight_ready = 1 (the FIFO is empty).
REQ-017 A reset during DRAIN or DONE SHALL abort the timestep, and no weight_done pulse SHALL be produced for it.

Configuration
REQ-018 With macro WEIGHT_COUNT_EN defined, the module SHALL add the following:
- Output port weight_count [7:0]: the number of weights accepted in the closed timestep.
- Counting saturates at 255.
- The count is latched with input_weight, cleared on DONE entry, and reset to 0.
REQ-019 Without WEIGHT_COUNT_EN, the weight_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-020 Reset: assert reset mid-cycle -> all outputs 0 immediately, weight_ready=1.
REQ-021 Basic sum: push 0x3F800000, 0x40000000, 0x3F000000, then timestep_end -> input_weight=0x40600000 (3.5), weight_done for 1 cycle, exception=0, weight_count=3.
REQ-022 Backpressure: 8 back-to-back valid cycles of 0x3F800000 with FIFO_DEPTH=4 -> weight_ready drops while the FIFO is full, all 8 accepted, input_weight=0x41000000 (8.0).
REQ-023 Empty timestep: timestep_end with no weights -> weight_done 2 cycles later, input_weight=0x00000000, weight_count=0.
REQ-024 Boundary timing: a weight accepted with timestep_end in the same cycle is included; a second timestep_end during DRAIN is ignored, giving exactly one weight_done pulse.
REQ-025 Reset mid-DRAIN with 3 weights queued -> no weight_done, FIFO empty, next timestep sums from 0x00000000.
